bt_rx_deframer: RTL and testbench
=================================

# bt_rx_deframer

Receive-direction Bluetooth link block for the dashcam SoC. It takes the serial RXD line from the external Bluetooth module (8N1 UART) and validates framed packets (SOF, length, payload, XOR checksum). It packs payload bytes little-endian into 32-bit words and presents them on a valid/ready stream with last/keep/error side-band. It is the counterpart of `bluetooth_ip`, which moves 32-bit words toward the module.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per UART bit (50 MHz / 115200); minimum 8.
- `FIFO_DEPTH`, default 8: output word FIFO depth; power of two, ≥ 2.
- `SOF_BYTE`, default 8'hA5: start-of-frame marker.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `bt_rxd`  in  1  serial line from the BT module; idle high; asynchronous.
- `data_out`  out  32  payload word; byte 0 in [7:0].
- `data_valid`  out  1  `data_out` and its side-band are valid.
- `data_ready`  in  1  consumer accepts the word when high with `data_valid`.
- `data_keep`  out  4  valid byte lanes. 4'b1111 except on a partial last word.
- `data_last`  out  1  final word of a frame.
- `data_err`  out  1  on the last word only: the frame failed its checksum or lost a word to overrun.
- `rx_overrun`  out  1  one-cycle pulse: a word was dropped because the FIFO was full.
- `line_err`  out  1  one-cycle pulse: bad stop bit, zero length, or false start.

## Operation
- **Reset:** all outputs are 0 and the FIFO is empty. The parser goes to HUNT and the UART to IDLE. Reset mid-frame discards the partial frame with no output.
- **Input:** 2-flop synchronizer on `bt_rxd`, reset value 1.
- **UART FSM** (IDLE, START, DATA, STOP):
  - A falling edge starts the bit counter.
  - The start bit is re-sampled at `CLKS_PER_BIT/2`. If it reads high, this is a false start: pulse `line_err` and return to IDLE.
  - Data bits are sampled at mid-bit, LSB first.
  - If the stop bit is 1, emit an internal byte strobe.
  - If the stop bit is 0, pulse `line_err`, drop the byte and reset the parser to HUNT.
- **Parser FSM** (HUNT, LEN, PAYLOAD, CSUM), one step per byte strobe:
  - HUNT: on a byte equal to `SOF_BYTE`, go to LEN. Other bytes are ignored silently.
  - LEN: byte N. N = 0 pulses `line_err` and returns to HUNT. Otherwise load the remaining count with N, set the checksum to N, clear the error flag, and go to PAYLOAD.
  - PAYLOAD: place the byte in lane (index mod 4) and XOR it into the checksum. When a word fills and bytes remain, push it with keep 4'b1111, last 0. When count reaches 0, hold the final (possibly partial) word and go to CSUM.
  - CSUM: set err = (byte ≠ checksum) | overrun flag. Push the held word with last 1, keep = lanes filled (N mod 4 = 0 → 4'b1111), and that err. Return to HUNT.
- **FIFO full on push:** drop the word, pulse `rx_overrun`, and set the frame's overrun flag. If the dropped word was the last word, the frame ends with no `data_last`; the consumer relies on `rx_overrun`.
- **Lane hygiene:** unused lanes of a partial word read 0.

## Timing
- The byte strobe fires at the stop-bit mid-sample, cycle T.
- A word push writes the FIFO at the T+1 edge. `data_valid` is high from T+2 when the FIFO was empty.
- Handshake: a transfer occurs on the cycle `data_valid && data_ready`. `data_out` and the side-band stay stable while `data_valid` is high and `data_ready` is low. `data_valid` never drops without a transfer.
- Simultaneous push and pop on a full FIFO is accepted: pop first, so no overrun.
- Throughput: one byte per 10·`CLKS_PER_BIT` cycles. The FIFO drains at up to one word per cycle.

## Structure
- Package `bt_pkg`:
  - UART state enum and parser state enum.
  - `SOF_BYTE` default.
  - A word struct {data[31:0], keep[3:0], last, err}.
  - The same struct is reused by `bluetooth_ip`-side framing.
- Sub-module `bt_uart_rx`: synchronizer, bit timing, and byte strobe with stop-bit error. It is reusable for other module links.
- The FIFO is instantiated from the shared synchronous FIFO.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- A5 03 11 22 33 03, `data_ready`=1 → one word 0x00332211, keep 0111, last 1, err 0.
- A5 08 01..08, csum 08^01^…^08 = 0x00 → words 0x04030201 (last 0) and 0x08070605 (keep 1111, last 1, err 0).
- A5 03 11 22 33 FF → word 0x00332211, last 1, err 1.
- A5 00, then a byte with stop bit 0, then a 4-cycle low glitch on `bt_rxd` → `line_err` pulses three times; parser stays in HUNT; no output words.
- `FIFO_DEPTH`=2, `data_ready`=0, 16-byte frame → third and fourth pushes dropped with two `rx_overrun` pulses; after release, two words with last 0 are delivered.
- Reset asserted mid-PAYLOAD, then a valid frame → no output from the aborted frame; the new frame is output correctly.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared types for the Bluetooth serial link blocks.
//   uart_state_t   : byte receiver states
//   parser_state_t : frame parser states
//   bt_word_t      : 32-bit stream word with keep/last/err side-band. The
//                    transmit-side framing uses the same word layout.
//   keep_upto()    : keep mask covering byte lanes 0..lane
package bt_pkg;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    typedef enum logic [1:0] {
        P_HUNT,
        P_LEN,
        P_PAYLOAD,
        P_CSUM
    } parser_state_t;

    localparam logic [7:0] BT_SOF_BYTE = 8'hA5;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        err;
    } bt_word_t;

    localparam int BT_WORD_W = $bits(bt_word_t);

    function automatic logic [3:0] keep_upto(input logic [1:0] lane);
        logic [3:0] k;
        case (lane)
            2'd0:    k = 4'b0001;
            2'd1:    k = 4'b0011;
            2'd2:    k = 4'b0111;
            default: k = 4'b1111;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/bt_sync_fifo.sv
// Shared single-clock FIFO, first-word-fall-through.
//   wr_en/wr_data/full : write side; a write while full is accepted only
//                        when a read happens in the same cycle
//   rd_en/rd_data/empty: read side; rd_data shows the head while !empty
module bt_sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 UART byte receiver.
//   clk, reset_n : clock, asynchronous active-low reset
//   rxd          : asynchronous serial input, idle high
//   rx_byte      : received byte, valid while byte_stb is high
//   byte_stb     : one-cycle strobe at the stop-bit mid-sample (stop bit = 1)
//   stop_err     : one-cycle pulse, stop bit sampled low (byte dropped)
//   false_start  : one-cycle pulse, start bit read high at its mid-point
module bt_uart_rx
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       stop_err,
    output logic       false_start
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    uart_state_t      state;
    uart_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic [2:0]       bit_idx;
    logic             bit_sample;
    logic [7:0]       shift;

    // Synchronizer stage; prev flop gives the falling-edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= U_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_clr ? '0 : cnt + 1'b1;
            if (state == U_START)
                bit_idx <= '0;
            else if (bit_sample)
                bit_idx <= bit_idx + 1'b1;
        end
    end

    // Counter restarts at the start-bit mid-point, so every later
    // full-bit count lands in the middle of a data or stop bit.
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        bit_sample  = 1'b0;
        byte_stb    = 1'b0;
        stop_err    = 1'b0;
        false_start = 1'b0;
        case (state)
            U_IDLE: begin
                if (rxd_prev && !rxd_sync) begin
                    state_nxt = U_START;
                    cnt_clr   = 1'b1;
                end
            end
            U_START: begin
                if (cnt == HALF_BIT) begin
                    cnt_clr = 1'b1;
                    if (rxd_sync) begin
                        false_start = 1'b1;
                        state_nxt   = U_IDLE;
                    end else begin
                        state_nxt = U_DATA;
                    end
                end
            end
            U_DATA: begin
                if (cnt == FULL_BIT) begin
                    cnt_clr    = 1'b1;
                    bit_sample = 1'b1;
                    if (bit_idx == 3'd7)
                        state_nxt = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt == FULL_BIT) begin
                    cnt_clr   = 1'b1;
                    state_nxt = U_IDLE;
                    if (rxd_sync)
                        byte_stb = 1'b1;
                    else
                        stop_err = 1'b1;
                end
            end
            default: state_nxt = U_IDLE;
        endcase
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (bit_sample)
            shift <= {rxd_sync, shift[7:1]};
    end

    assign rx_byte = shift;

endmodule

// File: rtl/bt_rx_deframer.sv
// Receive deframer for the Bluetooth module link.
// Frame: SOF, length N (1..255), N payload bytes, XOR checksum (seeded N).
// Payload is packed little-endian into 32-bit words on a valid/ready stream.
//   clk, reset_n   : clock, asynchronous active-low reset
//   bt_rxd         : serial line from the BT module (8N1, idle high)
//   data_out       : payload word, byte 0 in [7:0]
//   data_valid     : word and side-band valid
//   data_ready     : consumer accepts when high with data_valid
//   data_keep      : valid byte lanes
//   data_last      : final word of a frame
//   data_err       : last word only; checksum failure or an earlier overrun
//   rx_overrun     : pulse, a word was dropped on a full FIFO
//   line_err       : pulse, bad stop bit, zero length or false start
module bt_rx_deframer
    import bt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SOF_BYTE     = BT_SOF_BYTE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bt_rxd,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [3:0]  data_keep,
    output logic        data_last,
    output logic        data_err,
    output logic        rx_overrun,
    output logic        line_err
);

    logic [7:0]    rx_byte;
    logic          byte_stb;
    logic          stop_err;
    logic          false_start;

    parser_state_t p_state;
    parser_state_t p_state_nxt;
    logic [7:0]    remain;
    logic [7:0]    remain_dec;
    logic [1:0]    lane;
    logic [3:0]    held_keep;
    logic          ovf_flag;
    logic [7:0]    csum;
    logic [31:0]   word;
    logic [31:0]   word_fill;
    logic          push;
    bt_word_t      push_word;
    logic          zero_len;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          overrun;
    bt_word_t      fifo_rd;

    bt_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxd         (bt_rxd),
        .rx_byte     (rx_byte),
        .byte_stb    (byte_stb),
        .stop_err    (stop_err),
        .false_start (false_start)
    );

    assign remain_dec = remain - 8'd1;
    // The word register is cleared at each word boundary, so OR-ing the
    // new byte into its lane leaves unused lanes at zero.
    assign word_fill  = word | ({24'd0, rx_byte} << {lane, 3'b000});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_state   <= P_HUNT;
            remain    <= '0;
            lane      <= '0;
            held_keep <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            p_state <= p_state_nxt;
            if (byte_stb) begin
                case (p_state)
                    P_LEN: begin
                        remain   <= rx_byte;
                        lane     <= '0;
                        ovf_flag <= 1'b0;
                    end
                    P_PAYLOAD: begin
                        remain <= remain_dec;
                        lane   <= lane + 1'b1;
                        if (remain_dec == 8'd0)
                            held_keep <= keep_upto(lane);
                    end
                    default: ;
                endcase
            end
            if (overrun)
                ovf_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_stb) begin
            case (p_state)
                P_LEN: begin
                    csum <= rx_byte;
                    word <= '0;
                end
                P_PAYLOAD: begin
                    csum <= csum ^ rx_byte;
                    // A full word is pushed this cycle unless it is the
                    // frame's final word, which is held for the checksum.
                    word <= (lane == 2'd3 && remain_dec != 8'd0) ? '0 : word_fill;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        p_state_nxt = p_state;
        push        = 1'b0;
        push_word   = '0;
        zero_len    = 1'b0;
        if (stop_err) begin
            p_state_nxt = P_HUNT;
        end else if (byte_stb) begin
            case (p_state)
                P_HUNT: begin
                    if (rx_byte == SOF_BYTE)
                        p_state_nxt = P_LEN;
                end
                P_LEN: begin
                    if (rx_byte == 8'd0) begin
                        zero_len    = 1'b1;
                        p_state_nxt = P_HUNT;
                    end else begin
                        p_state_nxt = P_PAYLOAD;
                    end
                end
                P_PAYLOAD: begin
                    if (remain_dec == 8'd0) begin
                        p_state_nxt = P_CSUM;
                    end else if (lane == 2'd3) begin
                        push      = 1'b1;
                        push_word = '{data: word_fill, keep: 4'b1111, last: 1'b0, err: 1'b0};
                    end
                end
                P_CSUM: begin
                    push        = 1'b1;
                    push_word   = '{data: word, keep: held_keep, last: 1'b1,
                                    err: (rx_byte != csum) | ovf_flag};
                    p_state_nxt = P_HUNT;
                end
                default: p_state_nxt = P_HUNT;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so only push-on-full
    // without a pop loses the word.
    assign pop     = data_valid && data_ready;
    assign overrun = push && fifo_full && !pop;

    bt_sync_fifo #(.WIDTH(BT_WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (push_word),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_overrun <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            rx_overrun <= overrun;
            line_err   <= false_start | stop_err | zero_len;
        end
    end

    // FIFO storage is not reset; mask the head so outputs read 0 when empty.
    assign data_valid = !fifo_empty;
    assign data_out   = data_valid ? fifo_rd.data : '0;
    assign data_keep  = data_valid ? fifo_rd.keep : '0;
    assign data_last  = data_valid && fifo_rd.last;
    assign data_err   = data_valid && fifo_rd.err;

endmodule

// File: tb/tb_bt_rx_deframer.sv
// Bench for bt_rx_deframer: directed frames from the plan plus random
// frames, checked against a frame-level packing model. A second instance
// with a 2-deep FIFO shares the serial line and is used for the overrun case.
module tb_bt_rx_deframer;

    localparam int CPB = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bt_rxd = 1'b1;
    logic        data_ready = 1'b0;
    logic [31:0] data_out;
    logic        data_valid;
    logic [3:0]  data_keep;
    logic        data_last;
    logic        data_err;
    logic        rx_overrun;
    logic        line_err;

    logic        ready2 = 1'b1;
    logic [31:0] data_out2;
    logic        data_valid2;
    logic [3:0]  data_keep2;
    logic        data_last2;
    logic        data_err2;
    logic        rx_overrun2;
    logic        line_err2;

    always #5 clk = ~clk;

    bt_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .SOF_BYTE(8'hA5)) u_dut (
        .clk(clk), .reset_n(reset_n), .bt_rxd(bt_rxd),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .data_keep(data_keep), .data_last(data_last), .data_err(data_err),
        .rx_overrun(rx_overrun), .line_err(line_err)
    );

    bt_rx_deframer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(2), .SOF_BYTE(8'hA5)) u_dut_small (
        .clk(clk), .reset_n(reset_n), .bt_rxd(bt_rxd),
        .data_out(data_out2), .data_valid(data_valid2), .data_ready(ready2),
        .data_keep(data_keep2), .data_last(data_last2), .data_err(data_err2),
        .rx_overrun(rx_overrun2), .line_err(line_err2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    exp_t        exp_q[$];
    logic [7:0]  pl_q[$];
    exp_t        got2_q[$];
    exp_t        mon_e;
    exp_t        hold_e;
    logic        stall_prev = 1'b0;
    logic        rdy_random = 1'b0;
    int          lerr_cnt = 0;
    int          ovr_cnt  = 0;
    int          ovr2_cnt = 0;
    int          rx_words = 0;
    logic [31:0] last_data = '0;
    logic [3:0]  last_keep = '0;
    logic        last_err  = 1'b0;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            data_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Consumer-side monitor for the main instance.
    always @(negedge clk) begin
        if (reset_n) begin
            if (line_err)   lerr_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (stall_prev) begin
                check("hold_valid", 64'(data_valid), 64'd1);
                check("hold_word", 64'({data_out, data_keep, data_last, data_err}), 64'(hold_e));
            end
            if (data_valid && data_ready) begin
                check("word_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("data", 64'(data_out), 64'(mon_e.data));
                    check("keep", 64'(data_keep), 64'(mon_e.keep));
                    check("last", 64'(data_last), 64'(mon_e.last));
                    check("err",  64'(data_err),  64'(mon_e.err));
                end
                rx_words++;
                last_data = data_out;
                last_keep = data_keep;
                last_err  = data_err;
            end
            stall_prev = data_valid && !data_ready;
            hold_e     = {data_out, data_keep, data_last, data_err};
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_overrun2) ovr2_cnt++;
            if (data_valid2 && ready2)
                got2_q.push_back({data_out2, data_keep2, data_last2, data_err2});
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        bt_rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            bt_rxd = b[i];
            wait_cyc(CPB);
        end
        bt_rxd = stop_ok;
        wait_cyc(CPB);
        bt_rxd = 1'b1;
        wait_cyc(CPB / 2 + int'($urandom_range(0, CPB)));
    endtask

    function automatic logic [7:0] frame_sum();
        logic [7:0] s;
        s = 8'(pl_q.size());
        foreach (pl_q[i]) s ^= pl_q[i];
        return s;
    endfunction

    // Sends SOF, length, pl_q and the given checksum byte; queues the words
    // the frame should produce.
    task automatic send_frame(input logic [7:0] cs);
        int   n;
        exp_t e;
        n = pl_q.size();
        for (int w = 0; w * 4 < n; w++) begin
            e = '0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < n) begin
                    e.data[8*k +: 8] = pl_q[w*4+k];
                    e.keep[k]        = 1'b1;
                end
            end
            e.last = ((w + 1) * 4 >= n);
            e.err  = e.last && (cs != frame_sum());
            exp_q.push_back(e);
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        foreach (pl_q[i]) send_byte(pl_q[i], 1'b1);
        send_byte(cs, 1'b1);
    endtask

    task automatic fill_random(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 2000) begin
            wait_cyc(1);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(data_valid), 64'd0);
        check({tag, "_data"},  64'(data_out),   64'd0);
        check({tag, "_keep"},  64'(data_keep),  64'd0);
        check({tag, "_last"},  64'(data_last),  64'd0);
        check({tag, "_err"},   64'(data_err),   64'd0);
        check({tag, "_ovr"},   64'(rx_overrun), 64'd0);
        check({tag, "_lerr"},  64'(line_err),   64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int w0;
        logic [7:0] jb;

        wait_cyc(5);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        wait_cyc(5);

        // Directed frames, consumer always ready.
        pl_q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h03);
        wait_drain();
        check("f1_data", 64'(last_data), 64'h00332211);
        check("f1_keep", 64'(last_keep), 64'b0111);

        pl_q.delete();
        for (int i = 1; i <= 8; i++) pl_q.push_back(8'(i));
        send_frame(8'h00);
        wait_drain();
        check("f2_data", 64'(last_data), 64'h08070605);

        pl_q = {8'h11, 8'h22, 8'h33};
        send_frame(8'hFF);
        wait_drain();
        check("f3_err", 64'(last_err), 64'd1);

        // Zero length, bad stop bit mid-frame, false start.
        l0 = lerr_cnt;
        w0 = rx_words;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h5A, 1'b0);
        bt_rxd = 1'b0;
        wait_cyc(4);
        bt_rxd = 1'b1;
        wait_cyc(3 * CPB);
        check("line_err_count", 64'(lerr_cnt - l0), 64'd3);
        check("line_err_no_words", 64'(rx_words - w0), 64'd0);
        fill_random(6);
        send_frame(frame_sum());
        wait_drain();

        // Random frames with a random consumer.
        rdy_random = 1'b1;
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, 1'b1);
            end
            fill_random(int'($urandom_range(1, 10)));
            if ($urandom_range(0, 3) == 0)
                send_frame(frame_sum() ^ 8'($urandom_range(1, 255)));
            else
                send_frame(frame_sum());
        end
        wait_drain();

        // Reset in the middle of a payload.
        w0 = rx_words;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        reset_n = 1'b0;
        wait_cyc(3);
        check_idle_outputs("midreset");
        reset_n = 1'b1;
        wait_cyc(2 * CPB);
        fill_random(7);
        send_frame(frame_sum());
        wait_drain();
        check("abort_words", 64'(rx_words - w0), 64'd2);

        // Overrun on the 2-deep instance: 16-byte frame, consumer stalled.
        ready2 = 1'b0;
        wait_cyc(2);
        got2_q.delete();
        l0 = ovr2_cnt;
        fill_random(16);
        send_frame(frame_sum());
        wait_cyc(20);
        check("ovr_pulses", 64'(ovr2_cnt - l0), 64'd2);
        check("ovr_valid_held", 64'(data_valid2), 64'd1);
        ready2 = 1'b1;
        wait_cyc(20);
        check("ovr_word_count", 64'(got2_q.size()), 64'd2);
        if (got2_q.size() >= 2) begin
            check("ovr_w0_data", 64'(got2_q[0].data), 64'({pl_q[3], pl_q[2], pl_q[1], pl_q[0]}));
            check("ovr_w0_last", 64'(got2_q[0].last), 64'd0);
            check("ovr_w1_data", 64'(got2_q[1].data), 64'({pl_q[7], pl_q[6], pl_q[5], pl_q[4]}));
            check("ovr_w1_last", 64'(got2_q[1].last), 64'd0);
        end
        check("ovr_drained", 64'(data_valid2), 64'd0);
        wait_drain();
        check("main_no_overrun", 64'(ovr_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
